// File: rtl/sram_responder_model.sv
// Clocked 16-bit SRAM device model: post-reset clear sweep, READ_LATENCY-deep read pipe, saturating access counters.
// Optional macro SRAM_BYTE_MASK_EN: LB_N/UB_N gate write lanes and read drive lanes; without it they are ignored.
module sram_responder_model #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int MEM_WORDS    = 65536,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic              init_done,
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int HW = DATA_W / 2;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state_q;
  logic [AW-1:0]     clr_ptr_q;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  logic              ready;
  logic              sel;
  logic              wr_fire;
  logic              rd_fire;
  logic              drv;
  logic              out_vld;
  logic [AW-1:0]     addr;
  logic [1:0]        lane_en;
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] out_dat;
  logic              unused_pins;

  assign ready = (state_q == ST_READY);
  assign addr  = SRAM_ADDR[AW-1:0];
  assign sel   = ready & ~SRAM_CE_N;

`ifdef SRAM_BYTE_MASK_EN
  assign lane_en     = {~SRAM_UB_N, ~SRAM_LB_N};
  assign unused_pins = ^SRAM_ADDR;
`else
  assign lane_en     = 2'b11;
  assign unused_pins = ^{SRAM_ADDR, SRAM_LB_N, SRAM_UB_N};
`endif

  // A write with no enabled lane is a no-op and is not counted.
  assign wr_fire = sel & ~SRAM_WE_N & (|lane_en);
  assign rd_fire = sel & SRAM_WE_N & ~SRAM_OE_N;
  assign rd_word = mem_q[addr];
  assign wr_mask = {{HW{lane_en[1]}}, {HW{lane_en[0]}}};
  assign wr_word = (rd_word & ~wr_mask) | (SRAM_DQ & wr_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
      init_done <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == AW'(MEM_WORDS - 1)) begin
            state_q   <= ST_READY;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (wr_fire && (wr_count != '1)) wr_count <= wr_count + 32'd1;
          if (rd_fire && (rd_count != '1)) rd_count <= rd_count + 32'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready)       mem_q[clr_ptr_q] <= '0;
      else if (wr_fire) mem_q[addr]      <= wr_word;
    end
  end

  if (READ_LATENCY == 0) begin : g_comb
    assign out_vld = ready;
    assign out_dat = rd_word;
  end else begin : g_pipe
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]       dat_q [READ_LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_fire;
        for (int i = 1; i < READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_q[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) dat_q[i] <= dat_q[i-1];
    end

    assign out_vld = vld_q[READ_LATENCY-1];
    assign out_dat = dat_q[READ_LATENCY-1];
  end

  // Drive decision uses the pins of the current cycle, so a writer asserting WE_N never contends.
  assign drv = out_vld & ready & ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;

  assign SRAM_DQ[HW-1:0]      = (drv & lane_en[0]) ? out_dat[HW-1:0]      : {HW{1'bz}};
  assign SRAM_DQ[DATA_W-1:HW] = (drv & lane_en[1]) ? out_dat[DATA_W-1:HW] : {(DATA_W-HW){1'bz}};

endmodule

// File: tb/tb_sram_responder_model.sv
// Directed bench for sram_responder_model (MEM_WORDS=16, READ_LATENCY=1); undriven DQ bits read as 1 via pullup.
module tb_sram_responder_model;
  localparam logic [15:0] FLOAT = 16'hFFFF;

`ifdef SRAM_BYTE_MASK_EN
  localparam logic [15:0] EXP_PART   = 16'hAA11;
  localparam logic [15:0] EXP_BOTHHI = 16'hAA11;
  localparam logic [15:0] EXP_UBRD   = 16'hAAFF;
  localparam int          WR_AFTER   = 2;
`else
  localparam logic [15:0] EXP_PART   = 16'hAAAA;
  localparam logic [15:0] EXP_BOTHHI = 16'h5555;
  localparam logic [15:0] EXP_UBRD   = 16'h5555;
  localparam int          WR_AFTER   = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] dq_w;
  logic [15:0] tb_dat;
  logic        tb_en;
  logic [17:0] addr;
  logic        lb_n, ub_n, we_n, ce_n, oe_n;
  logic        init_done;
  logic [31:0] wr_count, rd_count;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] burst [4];

  assign dq_w = tb_en ? tb_dat : 16'hzzzz;
  pullup (dq_w);

  always #5 clk = ~clk;

  sram_responder_model #(
    .ADDR_W(18), .DATA_W(16), .MEM_WORDS(16), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq_w), .SRAM_ADDR(addr),
    .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .init_done(init_done), .wr_count(wr_count), .rd_count(rd_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    tb_en = 1'b0; tb_dat = '0; addr = '0;
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic lb, input logic ub);
    addr = a; tb_dat = d; tb_en = 1'b1;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; lb_n = lb; ub_n = ub;
    tick();
    set_idle();
  endtask

  task automatic set_read(input logic [17:0] a);
    tb_en = 1'b0; addr = a;
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; lb_n = 1'b0; ub_n = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    burst[0] = 16'h1234; burst[1] = 16'h5678; burst[2] = 16'h9ABC; burst[3] = 16'hDEF0;
    set_idle();
    rst = 1'b1;
    tick(); tick();
    check("rst_init_done", init_done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_dq", dq_w, FLOAT);
    rst = 1'b0;
    wait_init("init_latency");

    // Clear check and drive gating around a single read.
    set_read(5); #1;
    check("dq_before_accept", dq_w, FLOAT);
    tick();
    check("rd_clr5", dq_w, 16'h0000);
    check("rd_count_1", rd_count, 1);
    set_idle(); #1;
    check("dq_ce_hi", dq_w, FLOAT);

    do_write(3, 16'hBEEF, 1'b0, 1'b0);
    check("wr_count_1", wr_count, 1);
    set_read(3);
    tick();
    check("rd_beef", dq_w, 16'hBEEF);
    check("rd_count_2", rd_count, 2);
    we_n = 1'b0; #1;
    check("dq_we_lo", dq_w, FLOAT);
    we_n = 1'b1; oe_n = 1'b1; #1;
    check("dq_oe_hi", dq_w, FLOAT);
    tick();
    check("rd_count_oe_hi", rd_count, 2);
    oe_n = 1'b0; #1;
    check("dq_stage_empty", dq_w, FLOAT);

    do_write(4, 16'h5A5A, 1'b0, 1'b0);
    set_read(4);
    tick();
    check("wr_then_rd", dq_w, 16'h5A5A);

    for (int i = 0; i < 4; i++) do_write(18'(8 + i), burst[i], 1'b0, 1'b0);
    check("wr_count_burst", wr_count, 6);
    set_read(8);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_rd%0d", i), dq_w, burst[i]);
      if (i < 3) begin
        addr = 18'(9 + i);
        tick();
      end
    end
    check("rd_count_burst", rd_count, 7);

    do_write(21, 16'h0C0D, 1'b0, 1'b0);
    set_read(5);
    tick();
    check("alias_21_to_5", dq_w, 16'h0C0D);
    check("wr_count_7", wr_count, 7);

    // Reset, then reset again mid-sweep at clr_ptr=7.
    set_idle();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_init_done", init_done, 0);
    check("rst2_wr_count", wr_count, 0);
    check("rst2_rd_count", rd_count, 0);
    repeat (7) tick();
    check("init_mid_sweep", init_done, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst3_init_done", init_done, 0);
    wait_init("init_restart");
    set_read(21);
    tick();
    check("alias21_cleared", dq_w, 16'h0000);
    addr = 3;
    tick();
    check("addr3_cleared", dq_w, 16'h0000);
    check("rd_count_post_rst", rd_count, 2);

    // Byte lanes.
    set_idle();
    do_write(2, 16'h1111, 1'b0, 1'b0);
    do_write(2, 16'hAAAA, 1'b1, 1'b0);
    set_read(2);
    tick();
    check("lane_ub_write", dq_w, EXP_PART);
    do_write(2, 16'h5555, 1'b1, 1'b1);
    check("wr_count_lanes", wr_count, WR_AFTER);
    set_read(2);
    tick();
    check("lane_both_hi_write", dq_w, EXP_BOTHHI);
    lb_n = 1'b1; #1;
    check("lane_ub_read", dq_w, EXP_UBRD);
    check("rd_count_lanes", rd_count, 4);
    set_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
